prog_loader: RTL and testbench

- Writer side of the node instruction memory: receives a program as a byte stream over a valid/ready handshake, packs bytes into 21-bit opcodes and drives the instruction RAM write port.
- Publishes the program length and holds the node in reset while loading.
- Sits between the host byte link (UART receiver) and one node's instruction memory; the memory itself is not part of this block.

---
 rtl/prog_loader_if.sv | 34 +++
 rtl/prog_loader.sv | 172 +++++++++++++++++
 tb/tb_prog_loader.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// prog_loader_if: bundles the two buses of the program loader.
//   Byte stream (host -> loader): s_data, s_valid, s_ready
//     A byte is transferred on any rising edge with s_valid && s_ready.
//   RAM write port (loader -> instruction memory): wr_en, wr_addr, wr_data
//     wr_en is a one-cycle strobe; wr_addr/wr_data are valid while it is high.
// Modports:
//   master - host/memory side: drives the byte stream, observes the write port
//   slave  - loader side: accepts the byte stream, drives the write port
interface prog_loader_if;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [20:0] wr_data;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready,
    output wr_en,
    output wr_addr,
    output wr_data
  );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: writer side of a node's instruction memory.
// Receives a framed program as a byte stream, packs every 3 bytes into a
// 21-bit opcode and writes it to the instruction RAM. Frame layout:
//   header N (1..MAX_ENTRIES), 3*N data bytes (MSB first), checksum byte
//   checksum = XOR of header and all data bytes
// Ports:
//   clk         - system clock, all state on rising edge
//   reset       - asynchronous, active-low (0 = reset)
//   bus         - byte stream in + RAM write port out (prog_loader_if.slave)
//   num_entries - length of the last successfully loaded program (0 = none)
//   busy        - load in progress; used to hold the node in reset
//   load_done   - one-cycle pulse when a load completes with a good checksum
//   load_err    - sticky error: bad header or checksum mismatch
module prog_loader #(
  parameter int MAX_ENTRIES = 32,
  parameter int OPCODE_W    = 21
) (
  input  logic         clk,
  input  logic         reset,
  prog_loader_if.slave bus,
  output logic [5:0]   num_entries,
  output logic         busy,
  output logic         load_done,
  output logic         load_err
);

  typedef enum logic [1:0] {IDLE, DATA, CHECK, DONE} state_t;

  state_t              state;
  state_t              state_next;

  logic [5:0]          n_reg;
  logic [4:0]          addr;
  logic [1:0]          byte_idx;
  logic [7:0]          csum;
  // Holds {b0[4:0], b1} once two bytes of an opcode are in; b0[7:5] fall off.
  logic [12:0]         asm_reg;
  logic [OPCODE_W-1:0] packed_op;

  logic                ready;
  logic                hdr_ok;
  logic                last_opcode;
  logic                hdr_take;
  logic                hdr_bad;
  logic                data_take;
  logic                opcode_done;
  logic                chk_ok;
  logic                chk_bad;

  logic                wr_en_r;
  logic [4:0]          wr_addr_r;
  logic [OPCODE_W-1:0] wr_data_r;

  assign bus.s_ready = ready;
  assign bus.wr_en   = wr_en_r;
  assign bus.wr_addr = wr_addr_r;
  assign bus.wr_data = wr_data_r;

  assign hdr_ok      = (bus.s_data != 8'd0) && (32'(bus.s_data) <= 32'(MAX_ENTRIES));
  assign last_opcode = ({1'b0, addr} == (n_reg - 6'd1));
  assign packed_op   = {asm_reg, bus.s_data};

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next state and per-cycle strobes. s_ready is gated by reset so that
  // every output reads 0 while reset is held.
  always_comb begin
    state_next  = state;
    ready       = 1'b0;
    hdr_take    = 1'b0;
    hdr_bad     = 1'b0;
    data_take   = 1'b0;
    opcode_done = 1'b0;
    chk_ok      = 1'b0;
    chk_bad     = 1'b0;
    case (state)
      IDLE: begin
        ready = reset;
        if (bus.s_valid && reset) begin
          if (hdr_ok) begin
            hdr_take   = 1'b1;
            state_next = DATA;
          end else begin
            hdr_bad = 1'b1;
          end
        end
      end
      DATA: begin
        ready = 1'b1;
        if (bus.s_valid) begin
          data_take = 1'b1;
          if (byte_idx == 2'd2) begin
            opcode_done = 1'b1;
            if (last_opcode) state_next = CHECK;
          end
        end
      end
      CHECK: begin
        ready = 1'b1;
        if (bus.s_valid) begin
          if (bus.s_data == csum) begin
            chk_ok     = 1'b1;
            state_next = DONE;
          end else begin
            chk_bad    = 1'b1;
            state_next = IDLE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: counters, checksum, opcode assembly, RAM write and status.
  // addr only advances after a non-final write so it never wraps past N-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_reg       <= '0;
      addr        <= '0;
      byte_idx    <= '0;
      csum        <= '0;
      asm_reg     <= '0;
      wr_en_r     <= 1'b0;
      wr_addr_r   <= '0;
      wr_data_r   <= '0;
      num_entries <= '0;
      busy        <= 1'b0;
      load_done   <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      wr_en_r   <= opcode_done;
      load_done <= chk_ok;
      if (hdr_take) begin
        n_reg    <= bus.s_data[5:0];
        csum     <= bus.s_data;
        addr     <= '0;
        byte_idx <= '0;
        load_err <= 1'b0;
        busy     <= 1'b1;
      end
      if (hdr_bad) load_err <= 1'b1;
      if (data_take) begin
        csum     <= csum ^ bus.s_data;
        asm_reg  <= {asm_reg[4:0], bus.s_data};
        byte_idx <= opcode_done ? 2'd0 : byte_idx + 2'd1;
      end
      if (opcode_done) begin
        wr_addr_r <= addr;
        wr_data_r <= packed_op;
        if (!last_opcode) addr <= addr + 5'd1;
      end
      if (chk_ok) begin
        num_entries <= n_reg;
        busy        <= 1'b0;
      end
      if (chk_bad) begin
        load_err <= 1'b1;
        busy     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed self-checking bench for prog_loader.
// Drives framed programs through the interface, logs RAM writes at the
// falling edge and compares them with hand-computed opcodes.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] num_entries;
  logic       busy;
  logic       load_done;
  logic       load_err;

  always #5 clk = ~clk;

  prog_loader_if bus ();

  prog_loader #(
    .MAX_ENTRIES(32),
    .OPCODE_W   (21)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .num_entries(num_entries),
    .busy       (busy),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          ready_low_cnt = 0;
  int          busy_cnt = 0;
  logic [4:0]  wq_addr [$];
  logic [20:0] wq_data [$];
  int          wq_cyc [$];
  logic [20:0] exp_op [32];

  // Falling-edge monitor: log writes and count status cycles.
  always @(negedge clk) begin
    cyc++;
    if (bus.wr_en === 1'b1) begin
      wq_addr.push_back(bus.wr_addr);
      wq_data.push_back(bus.wr_data);
      wq_cyc.push_back(cyc);
    end
    if (load_done === 1'b1) done_cnt++;
    if (busy === 1'b1) busy_cnt++;
    if (reset === 1'b1 && bus.s_ready !== 1'b1) ready_low_cnt++;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
    done_cnt = 0;
    ready_low_cnt = 0;
    busy_cnt = 0;
  endtask

  // Present one byte and return #1 after the edge that accepted it.
  task automatic apply_stimulus(input logic [7:0] b);
    int k;
    k = 0;
    bus.s_data  = b;
    bus.s_valid = 1'b1;
    while (bus.s_ready !== 1'b1 && k < 8) begin
      @(negedge clk);
      k++;
    end
    if (k >= 8) check_output("s_ready_timeout", 32'(bus.s_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    bus.s_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Frame A: N=2, opcodes 0x1ABCDE and 0x000005; correct checksum is 0x7F.
  task automatic send_frame_a(input logic [7:0] csum_byte, input int max_gap);
    logic [7:0] fb [7];
    fb = '{8'h02, 8'h1A, 8'hBC, 8'hDE, 8'h00, 8'h00, 8'h05};
    for (int i = 0; i < 7; i++) begin
      if (max_gap > 0 && i > 0) idle_cycles(int'($urandom_range(0, max_gap)));
      apply_stimulus(fb[i]);
    end
    if (max_gap > 0) idle_cycles(int'($urandom_range(0, max_gap)));
    apply_stimulus(csum_byte);
    bus.s_valid = 1'b0;
  endtask

  task automatic check_frame_a_writes(input string tag);
    check_output({tag, "_nwr"}, 32'(wq_addr.size()), 32'd2);
    if (wq_addr.size() >= 2) begin
      check_output({tag, "_a0"}, 32'(wq_addr[0]), 32'd0);
      check_output({tag, "_d0"}, 32'(wq_data[0]), 32'h1ABCDE);
      check_output({tag, "_a1"}, 32'(wq_addr[1]), 32'd1);
      check_output({tag, "_d1"}, 32'(wq_data[1]), 32'h000005);
    end
  endtask

  initial begin
    logic [7:0]  cs;
    logic [20:0] op;
    int          max_gap;

    bus.s_data  = 8'h00;
    bus.s_valid = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_busy",    32'(busy),        32'd0);
    check_output("rst_num",     32'(num_entries), 32'd0);
    check_output("rst_err",     32'(load_err),    32'd0);
    check_output("rst_done",    32'(load_done),   32'd0);
    check_output("rst_wr_en",   32'(bus.wr_en),   32'd0);
    check_output("rst_s_ready", 32'(bus.s_ready), 32'd0);
    @(negedge clk) reset = 1'b1;
    #1;
    check_output("idle_ready", 32'(bus.s_ready), 32'd1);

    // Good N=2 frame, back-to-back
    clear_log();
    send_frame_a(8'h7F, 0);
    check_output("a_done",      32'(load_done),   32'd1);
    check_output("a_busy_low",  32'(busy),        32'd0);
    check_output("a_num",       32'(num_entries), 32'd2);
    check_output("a_ready_low", 32'(bus.s_ready), 32'd0);
    check_output("a_err",       32'(load_err),    32'd0);
    @(posedge clk);
    #1;
    check_output("a_done_pulse", 32'(load_done),   32'd0);
    check_output("a_ready_back", 32'(bus.s_ready), 32'd1);
    check_output("a_busy_cycles", 32'(busy_cnt),  32'd7);
    check_output("a_done_cnt",  32'(done_cnt),     32'd1);
    check_frame_a_writes("a");

    // Bad headers: 0 and MAX_ENTRIES+1
    clear_log();
    apply_stimulus(8'h00);
    bus.s_valid = 1'b0;
    check_output("h0_err",  32'(load_err), 32'd1);
    check_output("h0_busy", 32'(busy),     32'd0);
    idle_cycles(1);
    apply_stimulus(8'h21);
    bus.s_valid = 1'b0;
    check_output("h21_err",  32'(load_err), 32'd1);
    check_output("h21_busy", 32'(busy),     32'd0);
    idle_cycles(2);
    check_output("hbad_nwr",   32'(wq_addr.size()), 32'd0);
    check_output("hbad_busyc", 32'(busy_cnt),       32'd0);
    check_output("hbad_num",   32'(num_entries),    32'd2);

    // Same frame with random s_valid gaps; valid header clears load_err
    clear_log();
    send_frame_a(8'h7F, 3);
    check_output("g_done", 32'(load_done),   32'd1);
    check_output("g_num",  32'(num_entries), 32'd2);
    check_output("g_err",  32'(load_err),    32'd0);
    idle_cycles(1);
    check_frame_a_writes("g");
    check_output("g_done_cnt", 32'(done_cnt), 32'd1);

    // Checksum mismatch: writes stand, num_entries keeps its old value
    clear_log();
    send_frame_a(8'h7D, 0);
    check_output("c_err",   32'(load_err),    32'd1);
    check_output("c_busy",  32'(busy),        32'd0);
    check_output("c_done",  32'(load_done),   32'd0);
    check_output("c_num",   32'(num_entries), 32'd2);
    check_output("c_ready", 32'(bus.s_ready), 32'd1);
    idle_cycles(2);
    check_output("c_done_cnt", 32'(done_cnt), 32'd0);
    check_frame_a_writes("c");

    // Full-size N=32 frame with s_valid held high; b0[7:5] carry junk
    clear_log();
    cs = 8'h20;
    apply_stimulus(8'h20);
    check_output("f_err_cleared", 32'(load_err), 32'd0);
    for (int i = 0; i < 32; i++) begin
      op = 21'((i * 32'h0000C6A5) ^ (32'h000001F3 * (i + 1)));
      exp_op[i] = op;
      apply_stimulus({3'b101, op[20:16]});
      apply_stimulus(op[15:8]);
      apply_stimulus(op[7:0]);
      cs = cs ^ {3'b101, op[20:16]} ^ op[15:8] ^ op[7:0];
    end
    apply_stimulus(cs);
    bus.s_valid = 1'b0;
    check_output("f_done", 32'(load_done),   32'd1);
    check_output("f_num",  32'(num_entries), 32'd32);
    check_output("f_busy", 32'(busy),        32'd0);
    idle_cycles(1);
    check_output("f_nwr",       32'(wq_addr.size()), 32'd32);
    check_output("f_ready_low", 32'(ready_low_cnt),  32'd1);
    max_gap = 0;
    for (int i = 0; i < 32; i++) begin
      if (i < wq_addr.size()) begin
        check_output($sformatf("f_a%0d", i), 32'(wq_addr[i]), 32'(i));
        check_output($sformatf("f_d%0d", i), 32'(wq_data[i]), 32'(exp_op[i]));
        if (i > 0 && (wq_cyc[i] - wq_cyc[i-1]) > max_gap) max_gap = wq_cyc[i] - wq_cyc[i-1];
      end
    end
    check_output("f_gap_le3", 32'(max_gap <= 3), 32'd1);

    // Reset in the middle of an N=3 load, then an N=1 frame
    apply_stimulus(8'h03);
    apply_stimulus(8'h11);
    apply_stimulus(8'h22);
    apply_stimulus(8'h33);
    apply_stimulus(8'h44);
    bus.s_valid = 1'b0;
    check_output("m_busy_pre", 32'(busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    check_output("m_busy",  32'(busy),        32'd0);
    check_output("m_num",   32'(num_entries), 32'd0);
    check_output("m_wr_en", 32'(bus.wr_en),   32'd0);
    check_output("m_ready", 32'(bus.s_ready), 32'd0);
    check_output("m_err",   32'(load_err),    32'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    clear_log();
    apply_stimulus(8'h01);
    apply_stimulus(8'h00);
    apply_stimulus(8'h00);
    apply_stimulus(8'h07);
    apply_stimulus(8'h06);
    bus.s_valid = 1'b0;
    check_output("r_done", 32'(load_done),   32'd1);
    check_output("r_num",  32'(num_entries), 32'd1);
    idle_cycles(1);
    check_output("r_nwr", 32'(wq_addr.size()), 32'd1);
    if (wq_addr.size() >= 1) begin
      check_output("r_a0", 32'(wq_addr[0]), 32'd0);
      check_output("r_d0", 32'(wq_data[0]), 32'h000007);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
